// File: rtl/i2c_m_axil_pkg.sv
// rtl/i2c_m_axil_pkg.sv - shared constants and types for the I2C master AXI4-Lite register bank
// Optional feature macro: I2C_M_AXIL_SLVERR_EN
package i2c_m_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Register map as seen by the I2C engine
    localparam int REG_CTRL     = 0;
    localparam int REG_PRESCALE = 1;
    localparam int REG_TXDATA   = 2;
    localparam int REG_CMD      = 3;
    localparam int REG_STATUS   = 6;
    localparam int REG_RXDATA   = 7;

    // Response returned for accesses that are dropped (out of range, or write to a status slot)
    function automatic logic [1:0] reject_resp();
`ifdef I2C_M_AXIL_SLVERR_EN
        return RESP_SLVERR;
`else
        return RESP_OKAY;
`endif
    endfunction

endpackage

// File: rtl/i2c_m_axil_wchan.sv
// rtl/i2c_m_axil_wchan.sv - AW/W latching, write commit and B response
// Optional feature macro: I2C_M_AXIL_SLVERR_EN (error response via package)
module i2c_m_axil_wchan
    import i2c_m_axil_pkg::*;
#(
    parameter int          ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 8,
    parameter logic [15:0] RO_MASK    = 16'h00C0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    output logic                      commit_we,
    output logic [31:0]               commit_idx,
    output logic [DATA_WIDTH-1:0]     commit_data,
    output logic [DATA_WIDTH/8-1:0]   commit_strb
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);

    logic                    aw_held;
    logic                    w_held;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [DATA_WIDTH/8-1:0] w_strb_q;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    commit;
    logic                    writable;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    unused_addr_lo;

    // Ready is forced low while reset is asserted so nothing is accepted on the reset edge
    assign awready = !reset && !aw_held && !bvalid;
    assign wready  = !reset && !w_held && !bvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);

    assign cur_addr       = aw_held ? aw_addr_q : awaddr;
    assign commit_idx     = 32'(cur_addr[ADDR_WIDTH-1:ADDR_LSB]);
    assign commit_data    = w_held ? w_data_q : wdata;
    assign commit_strb    = w_held ? w_strb_q : wstrb;
    assign commit_we      = commit && writable;
    assign unused_addr_lo = ^cur_addr[ADDR_LSB-1:0];

    // Target is writable when it is in range and not a status slot
    always_comb begin
        writable = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_idx == 32'(i) && !RO_MASK[i]) writable = 1'b1;
        end
    end

    // Hold AW and W independently until both are present, then raise the B response
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= writable ? RESP_OKAY : reject_resp();
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                end
                if (bvalid && bready) bvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2c_m_axil_regs.sv
// rtl/i2c_m_axil_regs.sv - parametrised AXI4-Lite register bank for the I2C master
// Optional feature macro: I2C_M_AXIL_SLVERR_EN (SLVERR on dropped accesses)
module i2c_m_axil_regs
    import i2c_m_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          NUM_REGS           = 8,
    parameter logic [15:0] RO_MASK            = 16'h00C0
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]                    wr_pulse,
    output logic [NUM_REGS-1:0]                    rd_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int ADDR_LSB = $clog2(DW / 8);

    logic [DW-1:0]   regs [NUM_REGS];
    logic            commit_we;
    logic [31:0]     commit_idx;
    logic [DW-1:0]   commit_data;
    logic [DW/8-1:0] commit_strb;
    rd_state_t       state;
    rd_state_t       state_next;
    logic            ar_hs;
    logic [31:0]     ar_idx;
    logic [DW-1:0]   rd_val;
    logic            rd_in_range;
    logic            unused_inputs;

    i2c_m_axil_wchan #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_wchan (
        .clk         (s00_axi_aclk),
        .reset       (s00_axi_reset),
        .awaddr      (s00_axi_awaddr),
        .awvalid     (s00_axi_awvalid),
        .awready     (s00_axi_awready),
        .wdata       (s00_axi_wdata),
        .wstrb       (s00_axi_wstrb),
        .wvalid      (s00_axi_wvalid),
        .wready      (s00_axi_wready),
        .bresp       (s00_axi_bresp),
        .bvalid      (s00_axi_bvalid),
        .bready      (s00_axi_bready),
        .commit_we   (commit_we),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DW +: DW] = regs[g];
    end

    assign unused_inputs = ^{ro_in, s00_axi_araddr[ADDR_LSB-1:0]};

    // Byte-strobed update of the RW registers on a committed write
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < DW / 8; b++) begin
                    if (commit_idx == 32'(i) && commit_strb[b]) regs[i][b*8 +: 8] <= commit_data[b*8 +: 8];
                end
            end
        end
    end

    // One-cycle write strobe to the I2C core for each committed write
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) wr_pulse[i] <= commit_we && (commit_idx == 32'(i));
        end
    end

    assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
    assign ar_idx = 32'(s00_axi_araddr[AW-1:ADDR_LSB]);

    // Read source mux: status slots come from the core, others from the register array
    always_comb begin
        rd_val      = '0;
        rd_in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == 32'(i)) begin
                rd_in_range = 1'b1;
                rd_val      = RO_MASK[i] ? ro_in[i*DW +: DW] : regs[i];
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) state <= R_IDLE;
        else               state <= state_next;
    end

    // Read FSM next state
    always_comb begin
        state_next = state;
        case (state)
            R_IDLE: if (ar_hs) state_next = R_RESP;
            R_RESP: if (s00_axi_rready) state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        s00_axi_arready = (state == R_IDLE) && !s00_axi_reset;
        s00_axi_rvalid  = (state == R_RESP);
    end

    // Capture read data/response and strobe the core when an address is accepted
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            s00_axi_rdata <= '0;
            s00_axi_rresp <= RESP_OKAY;
            rd_pulse      <= '0;
        end else begin
            rd_pulse <= '0;
            if (ar_hs) begin
                s00_axi_rdata <= rd_val;
                s00_axi_rresp <= rd_in_range ? RESP_OKAY : reject_resp();
                for (int i = 0; i < NUM_REGS; i++) rd_pulse[i] <= (ar_idx == 32'(i));
            end
        end
    end

endmodule

// File: tb/tb_i2c_m_axil_regs.sv
// tb/tb_i2c_m_axil_regs.sv - scoreboard bench for i2c_m_axil_regs
module tb_i2c_m_axil_regs;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 8;
`ifdef I2C_M_AXIL_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b1;
    logic [AW-1:0]   araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b1;
    logic [NR*DW-1:0] reg_q;
    logic [NR*DW-1:0] ro_in;
    logic [NR-1:0]   wr_pulse;
    logic [NR-1:0]   rd_pulse;

    logic [DW-1:0]   mem [NR];
    logic [DW-1:0]   ro_val [NR];
    int              n_tests = 0;
    int              n_fail = 0;
    int              wr_cnt [NR];
    int              rd_cnt [NR];
    logic [1:0]      exp_b [$];
    logic [33:0]     exp_r [$];
    logic [1:0]      eb;
    logic [33:0]     er;

    always #5 clk = ~clk;

    i2c_m_axil_regs #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR),
        .RO_MASK            (16'h00C0)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_reset   (rst),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .reg_q           (reg_q),
        .ro_in           (ro_in),
        .wr_pulse        (wr_pulse),
        .rd_pulse        (rd_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0: return awready && wready;
            1: return arready;
            2: return bvalid;
            3: return rvalid;
            4: return awready && wready && arready;
            5: return awready;
            default: return wready;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        @(negedge clk);
        while (!sel(which) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sel(which)) check(tag, 64'(sel(which)), 64'd1);
    endtask

    function automatic logic writable(input logic [AW-1:0] a);
        int i = int'(a[AW-1:2]);
        return (i < NR) && (i != 6) && (i != 7);
    endfunction

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a[AW-1:2]);
        logic [NR-1:0] ep = '0;
        exp_b.push_back(writable(a) ? 2'b00 : ERR);
        if (writable(a)) begin
            ep[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (s[b]) mem[idx][b*8 +: 8] = d[b*8 +: 8];
        end
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        wait_for(0, "aw_w_ready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("b_latency", 64'(bvalid), 64'd1);
        check("wr_pulse_on", 64'(wr_pulse), 64'(ep));
        if (writable(a)) check("reg_q_update", 64'(reg_q[idx*DW +: DW]), 64'(mem[idx]));
        @(negedge clk);
        check("wr_pulse_off", 64'(wr_pulse), 64'd0);
        check("b_clear", 64'(bvalid), 64'd0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a);
        int idx = int'(a[AW-1:2]);
        logic [NR-1:0] ep = '0;
        logic [31:0] ed;
        logic [1:0] rs;
        if (idx >= NR) begin
            ed = '0; rs = ERR;
        end else begin
            ep[idx] = 1'b1; rs = 2'b00;
            ed = (idx >= 6) ? ro_val[idx] : mem[idx];
        end
        exp_r.push_back({rs, ed});
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        wait_for(1, "ar_ready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("r_latency", 64'(rvalid), 64'd1);
        check("rd_pulse_on", 64'(rd_pulse), 64'(ep));
        @(negedge clk);
        check("rd_pulse_off", 64'(rd_pulse), 64'd0);
        check("r_clear", 64'(rvalid), 64'd0);
    endtask

    // Scoreboard: pop and compare whenever a B or R beat completes; tally strobes
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) check("b_unexpected", 64'(bvalid), 64'd0);
                else begin
                    eb = exp_b.pop_front();
                    check("bresp", 64'(bresp), 64'(eb));
                end
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) check("r_unexpected", 64'(rvalid), 64'd0);
                else begin
                    er = exp_r.pop_front();
                    check("rdata", 64'(rdata), 64'(er[31:0]));
                    check("rresp", 64'(rresp), 64'(er[33:32]));
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (wr_pulse[i]) wr_cnt[i]++;
            if (rd_pulse[i]) rd_cnt[i]++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            mem[i] = '0; wr_cnt[i] = 0; rd_cnt[i] = 0;
            ro_val[i] = (i == 6) ? 32'hDEADBEEF : (i == 7) ? 32'h12345678 : 32'hFFFFFFFF;
            ro_in[i*DW +: DW] = ro_val[i];
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_resp", 64'({bresp, rresp}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_reg_q", 64'(|reg_q), 64'd0);
        check("rst_pulses", 64'({wr_pulse, rd_pulse}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'({awready, wready, arready}), 64'h7);

        // Basic write / read back
        for (int i = 0; i < 4; i++) axi_write(AW'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read(AW'(i * 4));
        for (int i = 0; i < 4; i++) check("wr_cnt_basic", 64'(wr_cnt[i]), 64'd1);

        // W two cycles ahead of AW with partial strobes
        axi_write(6'h04, 32'h11223344, 4'hF);
        mem[1] = 32'h1122A5A5;
        exp_b.push_back(2'b00);
        @(posedge clk); #1;
        wdata = 32'hA5A5A5A5; wstrb = 4'b0011; wvalid = 1'b1;
        wait_for(6, "w_ready");
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(negedge clk);
        check("w_held_ready", 64'(wready), 64'd0);
        check("b_early_1", 64'(bvalid), 64'd0);
        @(posedge clk); #1;
        awaddr = 6'h04; awvalid = 1'b1;
        @(negedge clk);
        check("aw_ready_late", 64'(awready), 64'd1);
        check("b_early_2", 64'(bvalid), 64'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check("b_after_aw", 64'(bvalid), 64'd1);
        check("wr_pulse_1", 64'(wr_pulse), 64'h2);
        check("reg1_merge", 64'(reg_q[DW +: DW]), 64'h1122A5A5);
        axi_read(6'h04);

        // Read and write to the same register in the same cycle
        exp_r.push_back({2'b00, mem[2]});
        exp_b.push_back(2'b00);
        mem[2] = 32'hCAFE0002;
        @(posedge clk); #1;
        awaddr = 6'h08; araddr = 6'h08; wdata = 32'hCAFE0002; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        wait_for(4, "all_ready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wait_for(3, "r_same_cycle");
        axi_read(6'h08);

        // Status slot: write dropped, read returns core value
        axi_write(6'h18, 32'h0, 4'hF);
        axi_read(6'h18);
        check("wr_cnt_ro", 64'(wr_cnt[6]), 64'd0);
        check("rd_cnt_ro", 64'(rd_cnt[6]), 64'd1);

        // Out of range
        axi_read(6'h3C);
        axi_write(6'h3C, 32'h77777777, 4'hF);

        // Back-pressure on B
        bready = 1'b0;
        exp_b.push_back(2'b00);
        mem[3] = 32'h0BADF00D;
        @(posedge clk); #1;
        awaddr = 6'h0C; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_for(0, "aw_w_ready_stall");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b_stall_valid", 64'(bvalid), 64'd1);
            check("b_stall_bresp", 64'(bresp), 64'd0);
            check("b_stall_ready", 64'({awready, wready}), 64'd0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);

        // Back-pressure on R
        rready = 1'b0;
        exp_r.push_back({2'b00, mem[3]});
        @(posedge clk); #1;
        araddr = 6'h0C; arvalid = 1'b1;
        wait_for(1, "ar_ready_stall");
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("r_stall_valid", 64'(rvalid), 64'd1);
            check("r_stall_data", 64'(rdata), 64'h0BADF00D);
            check("r_stall_ready", 64'(arready), 64'd0);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);

        // Reset with AW held and W pending
        @(posedge clk); #1;
        awaddr = 6'h00; awvalid = 1'b1;
        wait_for(5, "aw_ready_rst");
        @(posedge clk); #1;
        awvalid = 1'b0; wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rst_mid_wready", 64'(wready), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < NR; i++) mem[i] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_wr_pulse", 64'(wr_pulse), 64'd0);
            check("rst_mid_bvalid", 64'(bvalid), 64'd0);
            check("rst_mid_reg_q", 64'(|reg_q), 64'd0);
            check("rst_mid_ready", 64'({awready, wready}), 64'h3);
        end
        axi_write(6'h00, 32'h00000055, 4'hF);
        axi_read(6'h00);
        axi_read(6'h1C);

        repeat (3) @(negedge clk);
        check("exp_b_drained", 64'(exp_b.size()), 64'd0);
        check("exp_r_drained", 64'(exp_r.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
